// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, ROM address driver and decode-side
// valid/ready output with a one-entry skid buffer.
// Optional counters: define FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          PROG_WORDS = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_pc,
  input  logic [31:0] rom_inst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc8,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
`endif
  output logic        halted
);

  localparam logic [31:0] END_PC =
    RESET_PC + 32'(4 * PROG_WORDS);

  logic [31:0] pc_q, pc_d;
  logic        if_v_q;
  logic [31:0] if_pc_q;
  logic        sk_v_q;
  logic [31:0] sk_inst_q, sk_pc_q;
  logic        dv_q;
  logic [31:0] di_q, dp_q;
  logic        halted_q;

  logic in_range, out_free, issue, halt_c;

  // Issue decision and next PC
  always_comb begin
    in_range = pc_q < END_PC;
    out_free = !dv_q || dec_ready;
    issue    = !br_taken && out_free
               && !sk_v_q && in_range;
    halt_c   = !in_range && !if_v_q
               && !sk_v_q && !dv_q;
    pc_d     = issue ? pc_q + 32'd4 : pc_q;
  end

  // PC, in-flight tag, skid and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      if_v_q    <= 1'b0;
      if_pc_q   <= '0;
      sk_v_q    <= 1'b0;
      sk_inst_q <= '0;
      sk_pc_q   <= '0;
      dv_q      <= 1'b0;
      di_q      <= '0;
      dp_q      <= '0;
      halted_q  <= 1'b0;
    end else if (br_taken) begin
      pc_q     <= br_target & ~32'h3;
      if_v_q   <= 1'b0;
      sk_v_q   <= 1'b0;
      dv_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      if_v_q <= issue;
      if (issue)
        if_pc_q <= pc_q;
      if (out_free) begin
        if (sk_v_q) begin
          dv_q   <= 1'b1;
          di_q   <= sk_inst_q;
          dp_q   <= sk_pc_q;
          sk_v_q <= if_v_q;
          if (if_v_q) begin
            sk_inst_q <= rom_inst;
            sk_pc_q   <= if_pc_q;
          end
        end else if (if_v_q) begin
          dv_q <= 1'b1;
          di_q <= rom_inst;
          dp_q <= if_pc_q;
        end else begin
          dv_q <= 1'b0;
        end
      end else if (if_v_q) begin
        sk_v_q    <= 1'b1;
        sk_inst_q <= rom_inst;
        sk_pc_q   <= if_pc_q;
      end
      if (halt_c)
        halted_q <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] pf_q, pl_q;
  logic [31:0] drop;

  // An output word taken by decode in the
  // flush cycle is delivered, not dropped.
  always_comb begin
    drop = 32'(if_v_q) + 32'(sk_v_q)
         + 32'(dv_q && !dec_ready);
  end

  // Delivery and flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_q <= '0;
      pl_q <= '0;
    end else begin
      if (dv_q && dec_ready)
        pf_q <= pf_q + 32'd1;
      if (br_taken)
        pl_q <= pl_q + drop;
    end
  end

  assign perf_fetched = pf_q;
  assign perf_flushed = pl_q;
`endif

  assign rom_pc    = pc_q;
  assign dec_valid = dv_q;
  assign dec_inst  = di_q;
  assign dec_pc    = dp_q;
  assign dec_pc8   = dp_q + 32'd8;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random checks
// against an in-order program scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] END = 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_pc;
  logic [31:0] rom_inst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc8;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  logic [31:0] rom [0:4];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  int n_xfer;
  int idle;
  int pend;

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .rom_pc(rom_pc),
    .rom_inst(rom_inst),
    .br_taken(br_taken),
    .br_target(br_target),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_inst(dec_inst),
    .dec_pc(dec_pc),
    .dec_pc8(dec_pc8),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(
    input logic [31:0] a);
    if (a < END)
      return rom[int'(a[4:2])];
    return 32'hDEAD0000 ^ a;
  endfunction

  // ROM with one-cycle registered read
  always @(posedge clk)
    rom_inst <= rd(rom_pc);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rdy,
                      input logic br,
                      input logic [31:0] tgt);
    logic xfer, hold;
    logic [31:0] h_inst, h_pc;
    dec_ready = rdy;
    br_taken  = br;
    br_target = tgt;
    xfer = dec_valid && rdy && !rst;
    if (xfer) begin
      chk("xfer_range", 32'(exp_pc < END), 1);
      chk("xfer_pc", dec_pc, exp_pc);
      chk("xfer_inst", dec_inst, rd(exp_pc));
      chk("xfer_pc8", dec_pc8, exp_pc + 8);
      exp_pc += 4;
      n_xfer++;
      idle = 0;
    end else if (rdy && !br && !rst
                 && exp_pc < END) begin
      idle++;
    end
    hold = dec_valid && !rdy && !br && !rst;
    h_inst = dec_inst;
    h_pc = dec_pc;
    if (br || rst) idle = 0;
    if (br) exp_pc = tgt & ~32'h3;
    @(posedge clk);
    @(negedge clk);
    br_taken = 1'b0;
    if (hold) begin
      chk("hold_valid", 32'(dec_valid), 1);
      chk("hold_inst", dec_inst, h_inst);
      chk("hold_pc", dec_pc, h_pc);
    end
    if (br) begin
      chk("br_flush", 32'(dec_valid), 0);
      chk("br_unhalt", 32'(halted), 0);
      chk("br_rom_pc", rom_pc, tgt & ~32'h3);
    end
    if (!rst) begin
      chk("idle_bound", 32'(idle <= 2), 1);
      if (halted) begin
        chk("halt_all_done", exp_pc, END);
        chk("halt_empty", 32'(dec_valid), 0);
      end
      if (exp_pc == END && !halted) pend++;
      else pend = 0;
      chk("halt_latency", 32'(pend <= 2), 1);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched,
          32'(n_xfer));
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    exp_pc = 32'h0;
    n_xfer = 0;
    idle = 0;
    pend = 0;
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_inst", dec_inst, 0);
    chk("rst_pc", dec_pc, 0);
    chk("rst_pc8", dec_pc8, 8);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_rom_pc", rom_pc, 0);
  endtask

  initial begin
    int k;
    rom[0] = 32'hE3A02005;
    rom[1] = 32'hE52D2004;
    rom[2] = 32'hE52D2004;
    rom[3] = 32'hE49D3004;
    rom[4] = 32'hE49D4004;
    rst = 1'b1;
    dec_ready = 1'b0;
    br_taken = 1'b0;
    br_target = 32'h0;
    exp_pc = 32'h0;
    n_xfer = 0;
    idle = 0;
    pend = 0;
    @(negedge clk);

    // Straight-line program, ready held high
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    chk("first_not_yet", 32'(dec_valid), 0);
    tick(1'b1, 1'b0, 32'h0);
    chk("first_valid", 32'(dec_valid), 1);
    chk("first_inst", dec_inst, 32'hE3A02005);
    for (int i = 0; i < 5; i++) begin
      chk("consec_valid", 32'(dec_valid), 1);
      tick(1'b1, 1'b0, 32'h0);
    end
    tick(1'b1, 1'b0, 32'h0);
    chk("halted_set", 32'(halted), 1);
    chk("all_words", 32'(n_xfer), 5);

    // Restart from halt, then back-pressure
    tick(1'b1, 1'b1, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    chk("restart_inst", dec_inst, 32'hE3A02005);
    for (int i = 0; i < 4; i++)
      tick(1'b0, 1'b0, 32'h0);
    chk("bp_inst", dec_inst, 32'hE3A02005);
    chk("bp_rom_pc", rom_pc, 32'h8);

    // Branch to unaligned 6 when dec_pc is 4
    k = 0;
    while (!(dec_valid && dec_pc == 32'h4)
           && k < 10) begin
      tick(1'b1, 1'b0, 32'h0);
      k++;
    end
    chk("found_pc4",
        32'(dec_valid && dec_pc == 32'h4), 1);
    tick(1'b1, 1'b1, 32'h6);
    tick(1'b1, 1'b0, 32'h0);
    chk("br_bubble", 32'(dec_valid), 0);
    tick(1'b1, 1'b0, 32'h0);
    chk("br_tgt_valid", 32'(dec_valid), 1);
    chk("br_tgt_pc", dec_pc, 32'h4);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);

    // Flush while stalled with a full skid
    tick(1'b1, 1'b1, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h8);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    chk("flush_next_valid", 32'(dec_valid), 1);
    chk("flush_next_pc", dec_pc, 32'h8);

    // Random ready, branches and resets
    for (int i = 0; i < 600; i++) begin
      int r;
      logic rdy;
      r = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 2)
        do_reset();
      else if (r < 8)
        tick(rdy, 1'b1,
             32'($urandom_range(0, 19)));
      else
        tick(rdy, 1'b0, 32'h0);
    end

    // Mid-stream reset
    tick(1'b1, 1'b1, 32'h4);
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'b0, 32'h0);
    do_reset();
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    chk("post_rst_inst", dec_inst, 32'hE3A02005);
    chk("post_rst_pc", dec_pc, 32'h0);
    tick(1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
